// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Imported by the loader interface and the loader itself.
package loader_pkg;

  localparam int LOADER_DEPTH  = 32;
  localparam int LOADER_ADDR_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction memory write port of the loader.
// master = host/memory side, slave = loader side.
interface program_loader_if
  import loader_pkg::*;
#(
  parameter int ADDR_W = LOADER_ADDR_W
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/program_loader.sv
// Instruction memory writer: assembles 16-bit words from a byte
// stream, checks an XOR checksum and gates the cpu hold.
module program_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = LOADER_DEPTH,
  parameter int ADDR_W = LOADER_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  program_loader_if.slave   bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  loader_state_t    state_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       csum_q;
  logic [7:0]       hi_q;
  logic             acc;

  assign acc     = bus.in_valid && bus.in_ready;
  assign cnt_nxt = cnt_q + CNT_W'(1);

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      cnt_q        <= '0;
      csum_q       <= '0;
      hi_q         <= '0;
      bus.in_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_q      <= ST_COUNT;
            cnt_q        <= '0;
            csum_q       <= '0;
            bus.wr_addr  <= '0;
            bus.in_ready <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (acc) begin
            if (bus.in_data == 8'd0 ||
                bus.in_data > 8'(DEPTH)) begin
              state_q      <= ST_ERR;
              bus.in_ready <= 1'b0;
              error        <= 1'b1;
            end else begin
              n_q     <= bus.in_data[CNT_W-1:0];
              state_q <= ST_HI;
            end
          end
        end
        ST_HI: begin
          if (acc) begin
            hi_q    <= bus.in_data;
            csum_q  <= csum_q ^ bus.in_data;
            state_q <= ST_LO;
          end
        end
        ST_LO: begin
          if (acc) begin
            bus.wr_data  <= {hi_q, bus.in_data};
            csum_q       <= csum_q ^ bus.in_data;
            bus.wr_en    <= 1'b1;
            bus.in_ready <= 1'b0;
            state_q      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          bus.wr_addr  <= bus.wr_addr + ADDR_W'(1);
          cnt_q        <= cnt_nxt;
          bus.in_ready <= 1'b1;
          if (cnt_nxt == n_q) state_q <= ST_CHECK;
          else                state_q <= ST_HI;
        end
        ST_CHECK: begin
          if (acc) begin
            bus.in_ready <= 1'b0;
            if (bus.in_data == csum_q) begin
              state_q  <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              error   <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the instruction memory: receives a byte stream, assembles 16-bit instruction words high byte first, and issues one write per word into the instruction memory write port. It holds the processor in stall (`cpu_hold`) while memory contents are invalid and releases it only after a complete load with a matching checksum. It sits between the host byte link and the instruction memory, alongside the fetch/PC logic.

## Interface
- `DEPTH`, 32, instruction memory entries; legal word counts are 1..DEPTH
- `ADDR_W`, 5, write address width; must satisfy 2**ADDR_W >= DEPTH
- `clk`  input  1  single clock; all state changes on rising edge
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  single-cycle request to begin a load
- `in_valid`  input  1  byte-stream valid
- `in_data`  input  8  byte-stream data
- `in_ready`  output  1  loader can accept a byte this cycle
- `wr_en`  output  1  instruction memory write strobe, one cycle per word
- `wr_addr`  output  ADDR_W  write address
- `wr_data`  output  16  write data: {hi byte, lo byte}
- `cpu_hold`  output  1  processor stall; high unless memory holds a verified image
- `done`  output  1  load completed and verified
- `error`  output  1  load failed (bad count or checksum); sticky

## Operation
- Frame format: COUNT byte N, then N × (HI, LO), then one CHK byte; CHK = XOR of all 2N data bytes (COUNT excluded).
- Byte accepted on a rising edge where `in_valid && in_ready`.
- States: IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERR.
- IDLE: `start` -> COUNT. Clear word counter, address, checksum, `done`, `error`.
- COUNT: accept N. N==0 or N>DEPTH -> ERR; otherwise latch N -> HI.
- HI: accept byte into upper half, XOR into checksum -> LO.
- LO: accept byte into lower half, XOR into checksum -> WRITE.
- WRITE: `wr_en`=1 for exactly one cycle with current `wr_addr`/`wr_data`; then increment address and word count; if count == N -> CHECK, else -> HI.
- CHECK: accept CHK byte; equal to running XOR -> DONE, else -> ERR.
- DONE: `done`=1, `cpu_hold`=0. `start` -> COUNT (reload; `cpu_hold` re-asserts).
- ERR: `error`=1, `cpu_hold`=1. `start` -> COUNT.
- `start` in COUNT/HI/LO/WRITE/CHECK is ignored.
- `in_ready`=1 only in COUNT, HI, LO, CHECK; 0 in IDLE, WRITE, DONE, ERR. Bytes presented while `in_ready`=0 are not consumed.
- Words already written before an ERR remain in memory; `cpu_hold` guarantees they are never executed.
- Checksum and address arithmetic: 8-bit XOR; address increments by 1, never wraps because N ≤ DEPTH.

## Timing
- Reset values: state IDLE, `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=1, `done`=0, `error`=0.
- All outputs registered or decoded only from state registers; no combinational input->output path.
- `start` at edge k -> `in_ready`=1 from cycle k+1.
- LO byte accepted at edge k -> `wr_en`=1 during cycle k+1 -> `in_ready`=1 (HI or CHECK) from cycle k+2. Minimum 3 cycles per word.
- CHK accepted at edge k -> `done`/`error` valid and `cpu_hold` updated from cycle k+1.
- `rst` mid-load aborts immediately to reset values at the next edge; no `wr_en` issued afterwards.
- `rst` and `start` in the same cycle: `rst` wins.

## Structure
- Shared package `loader_pkg`: state enum `loader_state_t`, constant `LOADER_DEPTH`=32, constant `LOADER_ADDR_W`=5.
- Single module with no sub-modules; the FSM, counters, and checksum register are all local to it.

## Test plan
- Frame N=2, words 16'h0440, 16'h4F4F, CHK = 8'h04^8'h40^8'h4F^8'h4F = 8'h44 -> writes (0,0440), (1,4F4F), `done`=1, `cpu_hold`=0.
- COUNT=0, then COUNT=33 (with `start` between) -> ERR each time, `error`=1, `cpu_hold`=1, no `wr_en`.
- N=1, word 16'h1234, CHK=8'h00 -> one write at address 0, then ERR, `cpu_hold` stays 1.
- Same good frame with random `in_valid` gaps, and bytes held during WRITE -> identical writes, no byte lost or duplicated.
- `rst` after HI byte of word 3 in an N=5 load -> reset values next cycle; a fresh `start` plus a good frame loads correctly from address 0.
- `start` pulsed during LO -> ignored; full N=32 load -> last write at address 31, `done`=1.
